// File: rtl/elevator_request_latch.sv
// Button input stage for the 3-floor elevator: sync, debounce, request latch, SCAN next-target.
// Optional stuck-button detection is enabled by defining ELEV_REQ_STUCK_DETECT_EN.
module elevator_request_latch #(
  parameter int unsigned DEB_CYCLES   = 4
`ifdef ELEV_REQ_STUCK_DETECT_EN
  , parameter int unsigned STUCK_CYCLES = 1024
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] fb_n,
  input  logic [2:0] call_n,
  input  logic [1:0] cur_floor,
  input  logic       dir_up,
  input  logic       serve_valid,
  input  logic [1:0] serve_floor,
  output logic [2:0] fb_req,
  output logic [2:0] call_req,
  output logic       any_req,
  output logic [1:0] next_floor,
  output logic       next_valid
`ifdef ELEV_REQ_STUCK_DETECT_EN
  , output logic [5:0] stuck
`endif
);

  localparam int unsigned NIN = 6;
  localparam int unsigned CW  = $clog2(DEB_CYCLES + 1);

  logic [NIN-1:0] pins, sync1, sync2, deb, deb_prev, armed;
  logic [NIN-1:0] ev_c, stuck_mask_c, stuck_clr_c;
  logic [1:0]     warm;

  assign pins = {call_n, fb_n};

  // Synchroniser; armed marks inputs seen released since reset so a held button stays silent.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '1;
      sync2    <= '1;
      warm     <= '0;
      armed    <= '0;
      deb_prev <= '1;
    end else begin
      sync1    <= pins;
      sync2    <= sync1;
      warm     <= {warm[0], 1'b1};
      armed    <= armed | ({NIN{warm[1]}} & sync2);
      deb_prev <= deb;
    end
  end

  for (genvar i = 0; i < NIN; i++) begin : g_deb
    logic [CW-1:0] cnt_q;
    logic          deb_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
        deb_q <= 1'b1;
      end else if (sync2[i] == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        cnt_q <= '0;
        deb_q <= ~deb_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
    assign deb[i] = deb_q;
  end

`ifdef ELEV_REQ_STUCK_DETECT_EN
  localparam int unsigned SW = $clog2(STUCK_CYCLES + 1);

  for (genvar i = 0; i < NIN; i++) begin : g_stuck
    logic [SW-1:0] scnt_q;
    logic          st_q;
    always_ff @(posedge clk) begin
      if (reset || deb[i]) begin
        scnt_q <= '0;
        st_q   <= 1'b0;
      end else if (scnt_q != SW'(STUCK_CYCLES)) begin
        scnt_q <= scnt_q + SW'(1);
        if (scnt_q == SW'(STUCK_CYCLES - 1)) st_q <= 1'b1;
      end
    end
    assign stuck_clr_c[i]  = ~deb[i] & (scnt_q == SW'(STUCK_CYCLES - 1));
    assign stuck_mask_c[i] = st_q;
    assign stuck[i]        = st_q;
  end
`else
  assign stuck_mask_c = '0;
  assign stuck_clr_c  = '0;
`endif

  assign ev_c = deb_prev & ~deb & armed & ~stuck_mask_c;

  logic [2:0] clr_c;
  always_comb begin
    clr_c = '0;
    if (serve_valid) begin
      case (serve_floor)
        2'd1:    clr_c = 3'b001;
        2'd2:    clr_c = 3'b010;
        2'd3:    clr_c = 3'b100;
        default: clr_c = 3'b000;
      endcase
    end
  end

  // Clear beats set: a press at the floor whose doors are open is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      fb_req   <= '0;
      call_req <= '0;
    end else begin
      fb_req   <= (fb_req   | ev_c[2:0]) & ~clr_c & ~stuck_clr_c[2:0];
      call_req <= (call_req | ev_c[5:3]) & ~clr_c & ~stuck_clr_c[5:3];
    end
  end

  logic [2:0] pend_c;
  logic [1:0] cf_c, above_c, below_c, sel_c;
  logic       above_ok_c, below_ok_c, at_ok_c, sel_ok_c;

  // SCAN: keep going in the current direction, then reverse, then the current floor.
  always_comb begin
    pend_c     = fb_req | call_req;
    cf_c       = (cur_floor == 2'd0) ? 2'd1 : cur_floor;
    above_c    = 2'd0;
    above_ok_c = 1'b0;
    below_c    = 2'd0;
    below_ok_c = 1'b0;
    sel_c      = 2'd0;
    sel_ok_c   = 1'b0;
    if (cf_c == 2'd1 && pend_c[1]) begin
      above_c    = 2'd2;
      above_ok_c = 1'b1;
    end else if (cf_c != 2'd3 && pend_c[2]) begin
      above_c    = 2'd3;
      above_ok_c = 1'b1;
    end
    if (cf_c == 2'd3 && pend_c[1]) begin
      below_c    = 2'd2;
      below_ok_c = 1'b1;
    end else if (cf_c != 2'd1 && pend_c[0]) begin
      below_c    = 2'd1;
      below_ok_c = 1'b1;
    end
    at_ok_c = pend_c[cf_c - 2'd1];
    if (dir_up ? above_ok_c : below_ok_c) begin
      sel_c    = dir_up ? above_c : below_c;
      sel_ok_c = 1'b1;
    end else if (dir_up ? below_ok_c : above_ok_c) begin
      sel_c    = dir_up ? below_c : above_c;
      sel_ok_c = 1'b1;
    end else if (at_ok_c) begin
      sel_c    = cf_c;
      sel_ok_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      next_floor <= '0;
      next_valid <= 1'b0;
      any_req    <= 1'b0;
    end else begin
      next_floor <= sel_c;
      next_valid <= sel_ok_c;
      any_req    <= |pend_c;
    end
  end

endmodule

// File: tb/tb_elevator_request_latch.sv
// Bench for elevator_request_latch: directed button/serve scenarios against a behavioural model.
module tb_elevator_request_latch;

  localparam int DEB = 4;
  localparam int STK = 16;
  localparam int HN  = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] fb_n = 3'b111, call_n = 3'b111;
  logic [1:0] cur_floor = 2'd1;
  logic       dir_up = 1'b1;
  logic       serve_valid = 1'b0;
  logic [1:0] serve_floor = 2'd0;
  logic [2:0] fb_req, call_req;
  logic       any_req, next_valid;
  logic [1:0] next_floor;
`ifdef ELEV_REQ_STUCK_DETECT_EN
  logic [5:0] stuck;
`endif

  int checks = 0;
  int failures = 0;

  elevator_request_latch #(
    .DEB_CYCLES(DEB)
`ifdef ELEV_REQ_STUCK_DETECT_EN
    , .STUCK_CYCLES(STK)
`endif
  ) dut (
    .clk(clk), .reset(reset), .fb_n(fb_n), .call_n(call_n),
    .cur_floor(cur_floor), .dir_up(dir_up),
    .serve_valid(serve_valid), .serve_floor(serve_floor),
    .fb_req(fb_req), .call_req(call_req), .any_req(any_req),
    .next_floor(next_floor), .next_valid(next_valid)
`ifdef ELEV_REQ_STUCK_DETECT_EN
    , .stuck(stuck)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic isp(input logic [2:0] p, input int f);
    logic [1:0] k;
    k = 2'(f - 1);
    return p[k];
  endfunction

  // SCAN choice from the rules: direction first, then the reverse, then the current floor.
  function automatic int pick(input logic [2:0] pend, input logic [1:0] cur, input logic up);
    int c, r;
    c = (cur == 2'd0) ? 1 : int'(cur);
    r = 0;
    if (up) begin
      for (int f = 3; f > c; f--) if (isp(pend, f)) r = f;
      if (r == 0) for (int f = 1; f < c; f++) if (isp(pend, f)) r = f;
    end else begin
      for (int f = 1; f < c; f++) if (isp(pend, f)) r = f;
      if (r == 0) for (int f = 3; f > c; f--) if (isp(pend, f)) r = f;
    end
    if (r == 0 && isp(pend, c)) r = c;
    return r;
  endfunction

  // Model: a button's debounced level flips once the twice-delayed pin has held the
  // opposite level for DEB samples; a press counts only if seen released since reset.
  logic [5:0] m_hist [HN];
  logic [5:0] m_deb, m_fell, m_armed, m_stuck;
  int         m_scnt [6];
  logic [2:0] m_fb, m_call;
  logic       m_any, m_nv, mvalid = 1'b0;
  logic [1:0] m_nf;

  always @(posedge clk) begin : model
    logic [5:0] pin, dnew, set6, stclr;
    logic [2:0] clr, pend;
    logic       all;
    int         r;
    if (reset) begin
      for (int k = 0; k < HN; k++) m_hist[k[3:0]] = '1;
      for (int i = 0; i < 6; i++) m_scnt[i[2:0]] = 0;
      m_deb = '1; m_fell = '0; m_armed = '0; m_stuck = '0;
      m_fb = '0; m_call = '0; m_any = 1'b0; m_nv = 1'b0; m_nf = 2'd0;
      mvalid = 1'b1;
    end else begin
      pin  = {call_n, fb_n};
      pend = m_fb | m_call;
      r    = pick(pend, cur_floor, dir_up);
      m_nf = 2'(r);
      m_nv = (r != 0);
      m_any = |pend;
      clr = '0;
      if (serve_valid && serve_floor != 2'd0) clr[serve_floor - 2'd1] = 1'b1;
      set6  = m_fell & m_armed & ~m_stuck;
      stclr = '0;
`ifdef ELEV_REQ_STUCK_DETECT_EN
      for (int i = 0; i < 6; i++) begin
        if (m_deb[i[2:0]]) begin
          m_scnt[i[2:0]]  = 0;
          m_stuck[i[2:0]] = 1'b0;
        end else if (m_scnt[i[2:0]] < STK) begin
          m_scnt[i[2:0]]++;
          if (m_scnt[i[2:0]] == STK) begin
            m_stuck[i[2:0]] = 1'b1;
            stclr[i[2:0]]   = 1'b1;
          end
        end
      end
`endif
      m_fb   = (m_fb   | set6[2:0]) & ~clr & ~stclr[2:0];
      m_call = (m_call | set6[5:3]) & ~clr & ~stclr[5:3];
      for (int k = HN - 1; k > 0; k--) m_hist[k[3:0]] = m_hist[4'(k - 1)];
      m_hist[0] = pin;
      dnew = m_deb;
      for (int i = 0; i < 6; i++) begin
        all = 1'b1;
        for (int k = 2; k <= DEB + 1; k++)
          if (m_hist[k[3:0]][i[2:0]] == m_deb[i[2:0]]) all = 1'b0;
        if (all) dnew[i[2:0]] = ~m_deb[i[2:0]];
      end
      m_fell  = m_deb & ~dnew;
      m_deb   = dnew;
      m_armed = m_armed | pin;
    end
  end

  always @(negedge clk) begin : compare
    if (mvalid) begin
      chk("cyc_fb_req",     int'(fb_req),     int'(m_fb));
      chk("cyc_call_req",   int'(call_req),   int'(m_call));
      chk("cyc_any_req",    int'(any_req),    int'(m_any));
      chk("cyc_next_floor", int'(next_floor), int'(m_nf));
      chk("cyc_next_valid", int'(next_valid), int'(m_nv));
`ifdef ELEV_REQ_STUCK_DETECT_EN
      chk("cyc_stuck",      int'(stuck),      int'(m_stuck));
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic serve(input logic [1:0] f);
    serve_valid = 1'b1;
    serve_floor = f;
    cyc(1);
    serve_valid = 1'b0;
    serve_floor = 2'd0;
  endtask

  initial begin
    cyc(3);
    reset = 1'b0;
    cyc(5);
    chk("rst_fb_req", int'(fb_req), 0);
    chk("rst_call_req", int'(call_req), 0);
    chk("rst_next_valid", int'(next_valid), 0);
    chk("rst_next_floor", int'(next_floor), 0);
    chk("rst_any_req", int'(any_req), 0);

    // Clean press on car button 2: visible on the 7th edge after the fall.
    fb_n = 3'b101;
    cyc(6);
    chk("t1_fb_edge6", int'(fb_req), 0);
    cyc(1);
    chk("t1_fb_edge7", int'(fb_req), 3'b010);
    cyc(1);
    chk("t1_next_floor", int'(next_floor), 2);
    chk("t1_next_valid", int'(next_valid), 1);
    chk("t1_any_req", int'(any_req), 1);
    cyc(2);
    fb_n = 3'b111;
    cyc(8);
    serve(2'd2);
    chk("t1_served", int'(fb_req), 0);
    cyc(1);
    chk("t1_valid_drop", int'(next_valid), 0);

    // Short glitch on hall call 3.
    call_n = 3'b011;
    cyc(3);
    call_n = 3'b111;
    cyc(12);
    chk("t2_call_req", int'(call_req), 0);
    chk("t2_next_valid", int'(next_valid), 0);

    // Requests at 1 and 3, car at 2.
    cur_floor = 2'd2;
    dir_up = 1'b0;
    fb_n = 3'b110;
    call_n = 3'b011;
    cyc(10);
    fb_n = 3'b111;
    call_n = 3'b111;
    cyc(8);
    chk("t3_fb_req", int'(fb_req), 3'b001);
    chk("t3_call_req", int'(call_req), 3'b100);
    chk("t3_down", int'(next_floor), 1);
    dir_up = 1'b1;
    cyc(1);
    chk("t3_up", int'(next_floor), 3);
    cur_floor = 2'd3;
    cyc(1);
    chk("t3_top_up_reverse", int'(next_floor), 1);
    cur_floor = 2'd0;
    dir_up = 1'b0;
    cyc(1);
    chk("t3_floor0_down", int'(next_floor), 3);
    serve(2'd0);
    chk("t3_serve0_fb", int'(fb_req), 3'b001);
    chk("t3_serve0_call", int'(call_req), 3'b100);
    serve(2'd1);
    serve(2'd3);
    chk("t3_cleared", int'(fb_req | call_req), 0);
    cyc(1);
    chk("t3_valid_drop", int'(next_valid), 0);

    // Both floor-2 bits cleared by one serve; a press landing on the serve cycle is lost.
    cur_floor = 2'd1;
    dir_up = 1'b1;
    fb_n = 3'b101;
    call_n = 3'b101;
    cyc(7);
    chk("t4_fb_set", int'(fb_req), 3'b010);
    chk("t4_call_set", int'(call_req), 3'b010);
    cyc(1);
    fb_n = 3'b111;
    call_n = 3'b111;
    serve(2'd2);
    chk("t4_fb_clr", int'(fb_req), 0);
    chk("t4_call_clr", int'(call_req), 0);
    chk("t4_valid_lag", int'(next_valid), 1);
    cyc(1);
    chk("t4_valid_drop", int'(next_valid), 0);
    cyc(10);
    fb_n = 3'b101;
    cyc(6);
    serve(2'd2);
    chk("t4_lost_now", int'(fb_req), 0);
    cyc(2);
    chk("t4_lost_later", int'(fb_req), 0);
    chk("t4_lost_valid", int'(next_valid), 0);
    fb_n = 3'b111;
    cyc(10);

    // Button 3 held through a reset pulse.
    fb_n = 3'b011;
    cyc(2);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(15);
    chk("t5_held", int'(fb_req), 0);
    fb_n = 3'b111;
    cyc(8);
    chk("t5_released", int'(fb_req), 0);
    fb_n = 3'b011;
    cyc(8);
    chk("t5_repress", int'(fb_req), 3'b100);
    fb_n = 3'b111;
    cyc(8);
    serve(2'd3);
    cyc(2);

`ifdef ELEV_REQ_STUCK_DETECT_EN
    // Car button 1 held long enough to be flagged stuck.
    fb_n = 3'b110;
    cyc(40);
    chk("t6_stuck_set", int'(stuck), 6'b000001);
    chk("t6_req_cleared", int'(fb_req), 0);
    fb_n = 3'b111;
    cyc(10);
    chk("t6_stuck_clr", int'(stuck), 0);
    fb_n = 3'b110;
    cyc(8);
    chk("t6_repress", int'(fb_req), 3'b001);
    fb_n = 3'b111;
    cyc(8);
    serve(2'd1);
    cyc(2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
